// File: rtl/arya_sched_pkg.sv
// Shared types and default sizes for the core dispatch scheduler and its round-robin arbiters.
package arya_sched_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 64;
  localparam int CORE_IDX_W    = $clog2(NUM_CORES_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
  import arya_sched_pkg::*;
#(
  parameter int N  = NUM_CORES_DEF,
  parameter int IW = CORE_IDX_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  localparam int unsigned NU = N;

  logic        found;
  int unsigned c;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      c = (32'(ptr) + i) % NU;
      if (!found && req[c]) begin
        found   = 1'b1;
        pick[c] = 1'b1;
        idx     = IW'(c);
      end
    end
  end

endmodule

// File: rtl/core_dispatch_scheduler.sv
// Dispatches buffered packets round-robin to enabled cores and arbitrates the shared memory port.
// Optional watchdog with sticky core_fault output: define DISPATCH_WATCHDOG_EN.
module core_dispatch_scheduler
  import arya_sched_pkg::*;
#(
  parameter int NUM_CORES   = NUM_CORES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_BURST   = 8
`ifdef DISPATCH_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pkt_rdy,
  input  logic [ADDR_W-1:0]           pkt_start_addr,
  input  logic [ADDR_W-1:0]           pkt_end_addr,
  output logic                        proc_done,
  input  logic [NUM_CORES-1:0]        core_en,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [ADDR_W-1:0]           core_start_addr,
  output logic [ADDR_W-1:0]           core_end_addr,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES-1:0]        mem_req,
  input  logic [NUM_CORES*ADDR_W-1:0] mem_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] mem_req_wdata,
  input  logic [NUM_CORES-1:0]        mem_req_we,
  output logic [NUM_CORES-1:0]        mem_grant,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wen,
`ifdef DISPATCH_WATCHDOG_EN
  output logic [NUM_CORES-1:0]        core_fault,
`endif
  output logic                        busy,
  output logic                        overrun_err
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CORES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  sched_state_e         state_q, state_d;
  logic [IW-1:0]        sel_q, core_ptr_q, cs_idx;
  logic [NUM_CORES-1:0] elig, cs_pick;
  logic                 start_fire, core_finished, timeout;

  assign start_fire    = (state_q == SELECT) && (|elig);
  assign core_finished = core_done[sel_q] || !core_en[sel_q];
  assign busy          = (state_q != IDLE);

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_cnt_q;

  assign timeout = (state_q == WAIT) && (wd_cnt_q == WW'(TIMEOUT_CYC - 1));
  assign elig    = core_en & ~core_fault;

  // A normal done in the same cycle as the timeout wins; the core is not faulted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q   <= '0;
      core_fault <= '0;
    end else begin
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
      if (timeout && !core_finished) core_fault[sel_q] <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign elig    = core_en;
`endif

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_core_arb (
    .req  (elig),
    .ptr  (core_ptr_q),
    .pick (cs_pick),
    .idx  (cs_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_rdy) state_d = SELECT;
      SELECT:  if (start_fire) state_d = WAIT;
      WAIT:    if (core_finished || timeout) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      core_ptr_q      <= '0;
      core_start      <= '0;
      proc_done       <= 1'b0;
      core_start_addr <= '0;
      core_end_addr   <= '0;
      overrun_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= start_fire ? cs_pick : '0;
      proc_done  <= (state_q == RELEASE);
      if (state_q == IDLE && pkt_rdy) begin
        core_start_addr <= pkt_start_addr;
        core_end_addr   <= pkt_end_addr;
      end
      if (state_q != IDLE && pkt_rdy) overrun_err <= 1'b1;
      if (start_fire) begin
        sel_q      <= cs_idx;
        core_ptr_q <= next_idx(cs_idx);
      end
    end
  end

  // Memory arbiter: one arbiter instance serves both the idle pick and the burst hand-off;
  // while a grant is held it searches the other requesters starting just after the holder.
  logic [IW-1:0]        mem_idx_q, mem_ptr_q, ma_idx, ma_ptr;
  logic [BW-1:0]        burst_q;
  logic [NUM_CORES-1:0] others, ma_req, ma_pick;
  logic                 granted, holder_req, burst_done;

  assign granted    = |mem_grant;
  assign holder_req = mem_req[mem_idx_q];
  assign others     = mem_req & ~mem_grant;
  assign burst_done = (burst_q == BURST_LAST);
  assign ma_req     = granted ? others : mem_req;
  assign ma_ptr     = granted ? next_idx(mem_idx_q) : mem_ptr_q;

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_mem_arb (
    .req  (ma_req),
    .ptr  (ma_ptr),
    .pick (ma_pick),
    .idx  (ma_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_grant <= '0;
      mem_idx_q <= '0;
      mem_ptr_q <= '0;
      burst_q   <= '0;
    end else if (!granted) begin
      mem_grant <= ma_pick;
      mem_idx_q <= ma_idx;
      burst_q   <= '0;
    end else if (!holder_req) begin
      mem_grant <= '0;
      mem_ptr_q <= next_idx(mem_idx_q);
    end else if (burst_done && |others) begin
      mem_grant <= ma_pick;
      mem_idx_q <= ma_idx;
      mem_ptr_q <= next_idx(mem_idx_q);
      burst_q   <= '0;
    end else if (!burst_done) begin
      burst_q <= burst_q + 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (mem_grant[i]) begin
        mem_addr  = mem_req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = mem_req_wdata[i*DATA_W +: DATA_W];
        mem_wen   = mem_req_we[i] & mem_req[i];
      end
    end
  end

endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// Directed plus randomized bench for core_dispatch_scheduler against a behavioural model.
module tb_core_dispatch_scheduler;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, pkt_rdy, proc_done, mem_wen, busy, overrun_err;
  logic [AW-1:0]   pkt_start_addr, pkt_end_addr, core_start_addr, core_end_addr, mem_addr;
  logic [N-1:0]    core_en, core_start, core_done, mem_req, mem_req_we, mem_grant;
  logic [N*AW-1:0] mem_req_addr;
  logic [N*DW-1:0] mem_req_wdata;
  logic [DW-1:0]   mem_wdata;

  int checks   = 0;
  int failures = 0;

  // Model state: dispatch pointer, sticky overrun, memory owner / cycles held / pointer.
  int m_ptr   = 0;
  bit m_ovr   = 1'b0;
  int m_owner = -1;
  int m_held  = 0;
  int m_mptr  = 0;

  core_dispatch_scheduler #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pkt_rdy         (pkt_rdy),
    .pkt_start_addr  (pkt_start_addr),
    .pkt_end_addr    (pkt_end_addr),
    .proc_done       (proc_done),
    .core_en         (core_en),
    .core_start      (core_start),
    .core_start_addr (core_start_addr),
    .core_end_addr   (core_end_addr),
    .core_done       (core_done),
    .mem_req         (mem_req),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_we      (mem_req_we),
    .mem_grant       (mem_grant),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wen         (mem_wen),
    .busy            (busy),
    .overrun_err     (overrun_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_core(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  // From WAIT onwards: optional overrun pulse, noise dones, then the real finish.
  task automatic finish_packet(input int c, input logic [N-1:0] en, input logic [AW-1:0] sa,
                               input logic [AW-1:0] ea, input int delay, input bit drop_en,
                               input bit ovr);
    if (ovr) begin
      pkt_rdy = 1'b1;
      pkt_start_addr = ~sa;
      pkt_end_addr = ~ea;
      tick();
      pkt_rdy = 1'b0;
      m_ovr = 1'b1;
      check("overrun_set", 64'(overrun_err), 64'(1));
      check("overrun_addr_kept", 64'(core_start_addr), 64'(sa));
      check("overrun_no_start", 64'(core_start), 64'(0));
    end
    for (int d = 0; d < delay; d++) begin
      core_done = N'($urandom) & ~onehot(c);
      tick();
      core_done = '0;
      check("foreign_done_ignored", 64'(proc_done), 64'(0));
      check("start_one_cycle", 64'(core_start), 64'(0));
    end
    if (drop_en) core_en = en & ~onehot(c);
    else core_done = onehot(c);
    tick();
    core_done = '0;
    core_en = en;
    check("done_lat1", 64'(proc_done), 64'(0));
    check("busy_release", 64'(busy), 64'(1));
    check("start_addr_stable", 64'(core_start_addr), 64'(sa));
    check("end_addr_stable", 64'(core_end_addr), 64'(ea));
    tick();
    check("done_lat2", 64'(proc_done), 64'(1));
    check("busy_idle", 64'(busy), 64'(0));
    tick();
    check("done_pulse_end", 64'(proc_done), 64'(0));
    check("overrun_sticky", 64'(overrun_err), 64'(m_ovr));
  endtask

  task automatic run_packet(input logic [N-1:0] en, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                            input int delay, input bit drop_en, input bit ovr);
    int c;
    core_en = en;
    pkt_start_addr = sa;
    pkt_end_addr = ea;
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    pkt_start_addr = AW'($urandom);
    pkt_end_addr = AW'($urandom);
    check("busy_select", 64'(busy), 64'(1));
    check("start_lat1", 64'(core_start), 64'(0));
    c = pick_core(en, m_ptr);
    tick();
    check("core_start", 64'(core_start), 64'(onehot(c)));
    check("core_start_addr", 64'(core_start_addr), 64'(sa));
    check("core_end_addr", 64'(core_end_addr), 64'(ea));
    m_ptr = (c + 1) % N;
    finish_packet(c, en, sa, ea, delay, drop_en, ovr);
  endtask

  task automatic mem_cycle(input logic [N-1:0] r);
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_wen;
    mem_req = r;
    for (int i = 0; i < N; i++) begin
      mem_req_addr[i*AW +: AW] = AW'($urandom);
      mem_req_wdata[i*DW +: DW] = {$urandom, $urandom};
      mem_req_we[i] = 1'($urandom_range(0, 1));
    end
    #1;
    e_addr = '0;
    e_wd = '0;
    e_wen = 1'b0;
    if (m_owner >= 0) begin
      e_addr = mem_req_addr[m_owner*AW +: AW];
      e_wd = mem_req_wdata[m_owner*DW +: DW];
      e_wen = mem_req_we[m_owner] & r[m_owner];
    end
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", mem_wdata, e_wd);
    check("mem_wen", 64'(mem_wen), 64'(e_wen));
    @(posedge clk);
    if (m_owner < 0) begin
      m_owner = pick_core(r, m_mptr);
      m_held = (m_owner >= 0) ? 1 : 0;
    end else if (!r[m_owner]) begin
      m_mptr = (m_owner + 1) % N;
      m_owner = -1;
      m_held = 0;
    end else if (m_held >= MB && (r & ~onehot(m_owner)) != '0) begin
      m_mptr = (m_owner + 1) % N;
      m_owner = pick_core(r & ~onehot(m_owner), m_mptr);
      m_held = 1;
    end else begin
      m_held++;
    end
    #1;
    check("mem_grant", 64'(mem_grant), 64'(onehot(m_owner)));
  endtask

  initial begin
    logic [N-1:0] r;
    int c;
    reset = 1'b0;
    pkt_rdy = 1'b0;
    pkt_start_addr = '0;
    pkt_end_addr = '0;
    core_en = '0;
    core_done = '0;
    mem_req = '0;
    mem_req_addr = '0;
    mem_req_wdata = '0;
    mem_req_we = '0;
    tick();
    tick();
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_proc_done", 64'(proc_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(mem_grant), 64'(0));
    reset = 1'b1;
    tick();

    // Four packets, all cores enabled: strict rotation 0,1,2,3.
    for (int p = 0; p < 4; p++)
      run_packet(4'b1111, AW'(16 * p + 1), AW'(16 * p + 16), p % 3, 1'b0, 1'b0);

    // Sparse enable mask 1010 from pointer 0: cores 1, 3, 1.
    run_packet(4'b1010, 8'h12, 8'h34, 1, 1'b0, 1'b0);
    run_packet(4'b1010, 8'h56, 8'h78, 0, 1'b1, 1'b0);
    run_packet(4'b1010, 8'h9a, 8'hbc, 2, 1'b0, 1'b0);

    // No eligible core: SELECT holds until core 2 is enabled. End below start is legal.
    core_en = '0;
    pkt_start_addr = 8'hf5;
    pkt_end_addr = 8'h04;
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_no_start", 64'(core_start), 64'(0));
      check("stall_busy", 64'(busy), 64'(1));
    end
    core_en = 4'b0100;
    tick();
    c = pick_core(4'b0100, m_ptr);
    check("stall_release_start", 64'(core_start), 64'(onehot(c)));
    check("wrap_start_addr", 64'(core_start_addr), 64'(8'hf5));
    check("wrap_end_addr", 64'(core_end_addr), 64'(8'h04));
    m_ptr = (c + 1) % N;
    finish_packet(c, 4'b0100, 8'hf5, 8'h04, 1, 1'b0, 1'b0);

    // Packet arriving during WAIT is dropped and flags overrun.
    run_packet(4'b1111, 8'h21, 8'h43, 1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of WAIT with a live memory grant.
    mem_req = 4'b0010;
    mem_req_addr = {8'h44, 8'h33, 8'h22, 8'h11};
    mem_req_we = 4'b0010;
    core_en = 4'b1111;
    pkt_start_addr = 8'h77;
    pkt_end_addr = 8'h88;
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    tick();
    c = pick_core(4'b1111, m_ptr);
    check("pre_reset_start", 64'(core_start), 64'(onehot(c)));
    check("pre_reset_grant", 64'(mem_grant), 64'(4'b0010));
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async_core_start", 64'(core_start), 64'(0));
    check("async_proc_done", 64'(proc_done), 64'(0));
    check("async_start_addr", 64'(core_start_addr), 64'(0));
    check("async_end_addr", 64'(core_end_addr), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    check("async_overrun", 64'(overrun_err), 64'(0));
    check("async_grant", 64'(mem_grant), 64'(0));
    check("async_mem_addr", 64'(mem_addr), 64'(0));
    check("async_mem_wen", 64'(mem_wen), 64'(0));
    tick();
    mem_req = '0;
    mem_req_we = '0;
    mem_req_addr = '0;
    tick();
    reset = 1'b1;
    m_ptr = 0;
    m_ovr = 1'b0;
    tick();
    run_packet(4'b1111, 8'h0c, 8'h0d, 0, 1'b0, 1'b0);

    // Randomized dispatch traffic.
    for (int p = 0; p < 40; p++)
      run_packet(N'($urandom_range(1, 15)), AW'($urandom), AW'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    // Memory: cores 0 and 2 requesting continuously alternate every MB cycles.
    for (int k = 1; k <= 40; k++) begin
      mem_cycle(4'b0101);
      check("alt_grant", 64'(mem_grant), (((k - 1) / MB) % 2 == 0) ? 64'(4'b0001) : 64'(4'b0100));
    end
    mem_cycle(4'b0000);
    mem_cycle(4'b0010);
    mem_cycle(4'b0010);
    mem_cycle(4'b0010);
    mem_cycle(4'b0000);
    check("bubble_zero", 64'(mem_grant), 64'(0));
    mem_cycle(4'b0010);
    check("bubble_regrant", 64'(mem_grant), 64'(4'b0010));

    // Randomized, sticky-ish requests against the memory model.
    r = N'($urandom);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      mem_cycle(r);
    end
    mem_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_dispatch_scheduler.md
Name: core_dispatch_scheduler

Overview:
- Sits between the packet buffer controller and the processor cores.
- Takes one buffered packet at a time (start/end address plus ready pulse) and hands it to one idle, enabled core, chosen round-robin.
- Waits for that core's done, then returns a proc_done pulse to the buffer controller.
- Also round-robin arbitrates the single shared packet-memory port among all cores.

Parameters:
- NUM_CORES, 4, number of processor cores (2..8).
- ADDR_W, 8, packet memory address width.
- DATA_W, 64, packet memory data width.
- MAX_BURST, 8, maximum consecutive memory grant cycles while others request.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pkt_rdy  in  1  one-cycle pulse: packet buffered.
- pkt_start_addr  in  ADDR_W  first word address.
- pkt_end_addr  in  ADDR_W  last word address.
- proc_done  out  1  one-cycle pulse: packet processing complete.
- core_en  in  NUM_CORES  per-core enable mask.
- core_start  out  NUM_CORES  one-hot one-cycle start pulse.
- core_start_addr  out  ADDR_W  registered packet start, stable from start to done.
- core_end_addr  out  ADDR_W  registered packet end, stable from start to done.
- core_done  in  NUM_CORES  per-core done level/pulse.
- mem_req  in  NUM_CORES  per-core memory request.
- mem_req_addr  in  NUM_CORES*ADDR_W  packed per-core address; core i at bits [i*ADDR_W +: ADDR_W].
- mem_req_wdata  in  NUM_CORES*DATA_W  packed per-core write data.
- mem_req_we  in  NUM_CORES  per-core write enable.
- mem_grant  out  NUM_CORES  one-hot registered grant.
- mem_addr  out  ADDR_W  address muxed from the grantee.
- mem_wdata  out  DATA_W  write data muxed from the grantee.
- mem_wen  out  1  grantee's mem_req_we AND its mem_req; 0 when no grant.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun_err  out  1  sticky: pkt_rdy arrived while not IDLE.

Behaviour:
Reset (reset low, asynchronous):
- All outputs 0.
- FSM in IDLE.
- Both round-robin pointers at core 0.
- Watchdog counter 0.

Dispatch FSM:
- IDLE:
  - On pkt_rdy, latch both addresses into core_start_addr/core_end_addr and go to SELECT.
- SELECT:
  - Eligible set = core_en.
  - If empty, hold in SELECT (no timeout).
  - Otherwise pick the first eligible core at or after the rr pointer, wrapping NUM_CORES-1 -> 0.
  - Pulse that core's core_start bit for exactly one cycle.
  - Set the pointer to the selected core + 1 (mod NUM_CORES).
  - Go to WAIT.
- WAIT:
  - On core_done[sel], go to RELEASE. core_done from other cores is ignored.
  - If core_en[sel] drops, treat it as done.
- RELEASE:
  - Pulse proc_done for one cycle, then return to IDLE.
- Latency: pkt_rdy to core_start is 2 cycles; core_done to proc_done is 2 cycles.
- A pkt_rdy arriving in any state other than IDLE is dropped and sets overrun_err. overrun_err clears only on reset.
- pkt_end_addr < pkt_start_addr is legal (buffer wrap); addresses pass through unchanged.

Memory arbiter (independent of the FSM):
- Registered one-hot grant.
- When there is no current grant, grant the first requester at or after the mem rr pointer next cycle.
- A grantee keeps the grant while its mem_req stays high.
- If it holds for MAX_BURST cycles and any other core requests, the grant moves on next cycle.
- On grant release, pointer = grantee + 1.
- A dropped request frees the grant the following cycle, so there is a zero-grant bubble of 1 cycle.
- mem_addr, mem_wdata and mem_wen are combinational muxes of the grantee's signals.

Optional Feature:
- Macro DISPATCH_WATCHDOG_EN.
- When defined:
  - A counter runs in WAIT.
  - Reaching TIMEOUT_CYC forces RELEASE.
  - The selected core's bit is set in an added output core_fault[NUM_CORES] (sticky).
  - Faulted cores are excluded from the SELECT eligible set until reset.
- When undefined:
  - No counter and no core_fault port.
  - WAIT waits indefinitely.

Decomposition:
- Shared package arya_sched_pkg holds:
  - the FSM state encoding (IDLE, SELECT, WAIT, RELEASE, 2 bits);
  - the default NUM_CORES, ADDR_W and DATA_W constants;
  - the clog2-based core-index width constant.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs: request vector and pointer;
  - outputs: one-hot pick and index;
  - combinational.
  - Instantiated twice: core selection and memory grant.

Test Plan:
1. Reset during WAIT -> all outputs 0 immediately (asynchronous); the next pkt_rdy dispatches to core 0.
2. core_en=4'b1111, four sequential packets (start 0x01/end 0x10 etc.) -> core_start = 0001, 0010, 0100, 1000; each proc_done 2 cycles after core_done.
3. core_en=4'b1010 with pointer at 0 -> core 1 selected, then core 3, then core 1; with core_en=0, FSM stays in SELECT until bit 2 is set, then core 2 starts.
4. pkt_rdy pulsed while in WAIT -> packet ignored, overrun_err=1, core_start_addr unchanged.
5. Cores 0 and 2 request memory continuously, MAX_BURST=8 -> grant alternates every 8 cycles; mem_addr and mem_wen track the grantee. A single requester dropping req -> 1-cycle zero grant.
6. With DISPATCH_WATCHDOG_EN and TIMEOUT_CYC=16, the core never asserts done -> proc_done at WAIT cycle 16+1, core_fault bit set, and that core is skipped on the next dispatch.
